// File: rtl/cla_pkg.sv
// Shared constants and types for the two-level carry-lookahead adder.
package cla_pkg;
  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;

  typedef logic [CLA_WIDTH-1:0] word_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/cla4.sv
// 4-bit lookahead group: internal carries from ci, plus group generate/propagate.
module cla4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 G,
  output logic                 P
);
  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products of ci and the bit g/p terms.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
endmodule

// File: rtl/cla_high.sv
// Registered WIDTH-bit two-level carry-lookahead adder.
// Define CLA_HIGH_INREG_EN to also register the operands (latency 2 instead of 1).
module cla_high
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             ci_p0;

`ifdef CLA_HIGH_INREG_EN
  // Stage 0: operand registers ahead of the lookahead logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p0  <= '0;
      b_p0  <= '0;
      ci_p0 <= 1'b0;
    end else begin
      a_p0  <= number1;
      b_p0  <= number2;
      ci_p0 <= cin;
    end
  end
`else
  assign a_p0  = number1;
  assign b_p0  = number2;
  assign ci_p0 = cin;
`endif

  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [WIDTH-1:0] s_grp;
  logic [NG:0]      gc;
  gp_t              gp [NG];

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4 u_cla4 (
      .a  (a_p0[CLA_GROUP*k +: CLA_GROUP]),
      .b  (b_p0[CLA_GROUP*k +: CLA_GROUP]),
      .ci (gc[k]),
      .s  (s_grp[CLA_GROUP*k +: CLA_GROUP]),
      .G  (grp_g[k]),
      .P  (grp_p[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      gp[k].g = grp_g[k];
      gp[k].p = grp_p[k];
    end
  end

  // Second-level lookahead: each group carry is an independent sum of products
  // of cin and the group G/P terms, so no carry passes through another group.
  always_comb begin
    logic acc;
    logic term;
    gc   = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      term = ci_p0;
      for (int m = 0; m < k; m++) term = term & gp[m].p;
      acc = term;
      for (int j = 0; j < k; j++) begin
        term = gp[j].g;
        for (int m = j + 1; m < k; m++) term = term & gp[m].p;
        acc = acc | term;
      end
      gc[k] = acc;
    end
  end

  // Output stage: registered sum and carry-out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s_grp;
      cout <= gc[NG];
    end
  end
endmodule

// File: tb/tb_cla_high.sv
// Bench for cla_high: directed vector table, reset/hold sequences, random vs. reference add.
module tb_cla_high;
`ifdef CLA_HIGH_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] number1 = '0;
  logic [31:0] number2 = '0;
  logic        cin = 1'b0;
  logic [31:0] sum;
  logic        cout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cla_high #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .number1 (number1),
    .number2 (number2),
    .cin     (cin),
    .sum     (sum),
    .cout    (cout)
  );

  typedef struct {
    string       name;
    logic [31:0] n1;
    logic [31:0] n2;
    logic        ci;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl [8];
  logic [32:0] q [$];

  task automatic check(input string name, input logic [32:0] exp);
    vectors++;
    if ({cout, sum} !== exp) begin
      miscompares++;
      $display("FAIL %s: got cout=%b sum=%h, want cout=%b sum=%h",
               name, cout, sum, exp[32], exp[31:0]);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    number1 = a;
    number2 = b;
    cin     = c;
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  initial begin
    tbl[0] = '{"basic_41_32",     32'd41,        32'd32,        1'b0, 33'h0_00000049};
    tbl[1] = '{"cin_only",        32'hFFFFFFFF,  32'h00000000,  1'b1, 33'h1_00000000};
    tbl[2] = '{"full_chain",      32'hFFFFFFFF,  32'h00000001,  1'b0, 33'h1_00000000};
    tbl[3] = '{"to_msb",          32'h7FFFFFFF,  32'h00000001,  1'b0, 33'h0_80000000};
    tbl[4] = '{"group0_boundary", 32'h0000000F,  32'h00000001,  1'b0, 33'h0_00000010};
    tbl[5] = '{"msb_pair_cin",    32'h80000000,  32'h80000000,  1'b1, 33'h1_00000001};
    tbl[6] = '{"multi_group",     32'h0000FFFF,  32'h00000001,  1'b0, 33'h0_00010000};
    tbl[7] = '{"all_ones_cin",    32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 33'h1_FFFFFFFF};

    // Reset held low: outputs zero, inputs ignored across edges.
    #2;
    check("reset_initial", 33'h0);
    number1 = 32'hDEADBEEF;
    number2 = 32'h01234567;
    cin     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ignores_inputs", 33'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].n1, tbl[i].n2, tbl[i].ci);
      repeat (LAT) @(posedge clk);
      #1;
      check(tbl[i].name, tbl[i].exp);
    end

    // Inputs changing between edges must not reach the outputs.
    drive(32'h00000100, 32'h00000200, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    check("hold_before", 33'h0_00000300);
    number1 = 32'hAAAAAAAA;
    number2 = 32'h55555555;
    cin     = 1'b1;
    #2;
    check("hold_between_edges", 33'h0_00000300);

    // Reset asserted mid-stream.
    drive(32'h12345678, 32'h11111111, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    check("pre_reset_value", 33'h0_23456789);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_clear", 33'h0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 33'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("after_release_no_edge", 33'h0);
    repeat (LAT) @(posedge clk);
    #1;
    check("post_reset_value", 33'h0_23456789);

    // Back-to-back random against a delayed reference add.
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(0, 1));
      case (i % 16)
        0: a = 32'hFFFFFFFF;
        1: b = ~a;
        default: ;
      endcase
      drive(a, b, c);
      q.push_back(ref_add(a, b, c));
      @(posedge clk);
      #1;
      if (q.size() == LAT) check("random", q.pop_front());
    end
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      check("random_drain", q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
